// File: rtl/hls_ctl_mc_if.sv
// Host CSR bus (Avalon-MM slave side) for the HLS match-engine control block.
// Word-addressed, fixed read latency of one cycle, no wait states.
interface hls_ctl_mc_if;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        readdata_valid;
    logic        waitrequest;

    modport master (
        output address, write, writedata, read,
        input  readdata, readdata_valid, waitrequest
    );

    modport slave (
        input  address, write, writedata, read,
        output readdata, readdata_valid, waitrequest
    );
endinterface

// File: rtl/hls_ctl_mc.sv
// Multi-channel control/status for Aho-Corasick HLS kernels: pointers,
// soft-reset stretching, start/busy tracking and per-channel result FIFOs.
module hls_ctl_mc #(
    parameter int CH_CNT    = 4,
    parameter int PTR_W     = 64,
    parameter int RES_W     = 32,
    parameter int RES_DEPTH = 8,
    parameter int RST_PULSE = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    hls_ctl_mc_if.slave             csr,
    input  logic [CH_CNT-1:0]       res_write_i,
    input  logic [CH_CNT*RES_W-1:0] res_data_i,
    input  logic [CH_CNT-1:0]       done_i,
    output logic [CH_CNT-1:0]       rst_o,
    output logic [CH_CNT-1:0]       start_o,
    output logic [CH_CNT*PTR_W-1:0] ptr_o
);
    localparam int AW = $clog2(RES_DEPTH);
    localparam int CW = $clog2(RST_PULSE + 1);
    localparam logic [3:0] CH_N = 4'(CH_CNT);
    localparam logic [AW:0] FULL = (AW+1)'(RES_DEPTH);

    logic [PTR_W-1:0] ptr [CH_CNT];
    logic [31:0]      shadow;
    logic [2:0]       ch_sel;
    logic [CH_CNT-1:0] busy, ovf;
    logic [CW-1:0]    rcnt [CH_CNT];
    logic [RES_W-1:0] mem  [CH_CNT][RES_DEPTH];
    logic [AW-1:0]    wp [CH_CNT];
    logic [AW-1:0]    rp [CH_CNT];
    logic [AW:0]      cnt [CH_CNT];

    logic [31:0] wd;
    logic wr_ctrl, wr_sel, wr_lo, wr_hi, wr_clr, rd_pop;

    assign wd      = csr.writedata;
    assign wr_ctrl = csr.write && csr.address == 3'd0;
    assign wr_sel  = csr.write && csr.address == 3'd2;
    assign wr_lo   = csr.write && csr.address == 3'd3;
    assign wr_hi   = csr.write && csr.address == 3'd4;
    assign wr_clr  = csr.write && csr.address == 3'd7;
    assign rd_pop  = csr.read  && csr.address == 3'd5;
    assign csr.waitrequest = 1'b0;

    logic [CH_CNT-1:0] in_rst, start_ok, pop, push, push_ok, ovf_set;
    logic [PTR_W-1:0]  sel_ptr;
    logic [RES_W-1:0]  sel_head;
    logic [AW:0]       sel_cnt;
    logic [7:0]        busy8, ne8, ovf8;

    always_comb begin
        in_rst   = '0;
        start_ok = '0;
        pop      = '0;
        push     = '0;
        push_ok  = '0;
        ovf_set  = '0;
        sel_ptr  = '0;
        sel_head = '0;
        sel_cnt  = '0;
        busy8    = '0;
        ne8      = '0;
        ovf8     = '0;
        for (int c = 0; c < CH_CNT; c++) begin
            in_rst[c]   = rcnt[c] != '0;
            start_ok[c] = wr_ctrl && wd[8+c] && !wd[c]
                          && !in_rst[c] && !busy[c];
            pop[c]      = rd_pop && ch_sel == 3'(c) && cnt[c] != '0;
            push[c]     = res_write_i[c] && !in_rst[c];
            // A pop in the same cycle frees the slot a full-FIFO push needs
            push_ok[c]  = push[c] && (cnt[c] != FULL || pop[c]);
            ovf_set[c]  = push[c] && !push_ok[c];
            busy8[c]    = busy[c];
            ne8[c]      = cnt[c] != '0;
            ovf8[c]     = ovf[c];
            if (ch_sel == 3'(c)) begin
                sel_ptr  = ptr[c];
                sel_head = mem[c][rp[c]];
                sel_cnt  = cnt[c];
            end
        end
    end

    logic [31:0] rdata;

    always_comb begin
        rdata = '0;
        unique case (csr.address)
            3'd0: rdata = '0;
            3'd1: rdata = {8'd0, ovf8, ne8, busy8};
            3'd2: rdata = {29'd0, ch_sel};
            3'd3: rdata = sel_ptr[31:0];
            3'd4: rdata = 32'(sel_ptr[PTR_W-1:32]);
            3'd5: rdata = sel_cnt != '0 ? 32'(sel_head) : '0;
            3'd6: rdata = 32'(sel_cnt);
            3'd7: rdata = '0;
        endcase
    end

    for (genvar g = 0; g < CH_CNT; g++) begin : g_out
        assign rst_o[g] = !rst_n_i || in_rst[g];
        assign ptr_o[g*PTR_W +: PTR_W] = ptr[g];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            shadow             <= '0;
            ch_sel             <= '0;
            busy               <= '0;
            ovf                <= '0;
            start_o            <= '0;
            csr.readdata       <= '0;
            csr.readdata_valid <= 1'b0;
            for (int c = 0; c < CH_CNT; c++) begin
                ptr[c]  <= '0;
                rcnt[c] <= '0;
                wp[c]   <= '0;
                rp[c]   <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            csr.readdata_valid <= csr.read;
            csr.readdata       <= csr.read ? rdata : '0;
            if (wr_sel && {1'b0, wd[2:0]} < CH_N)
                ch_sel <= wd[2:0];
            if (wr_lo)
                shadow <= wd;
            for (int c = 0; c < CH_CNT; c++) begin
                if (wr_hi && ch_sel == 3'(c))
                    ptr[c] <= {wd[PTR_W-33:0], shadow};
                if (wr_ctrl && wd[c])
                    rcnt[c] <= CW'(RST_PULSE);
                else if (in_rst[c])
                    rcnt[c] <= rcnt[c] - CW'(1);
                start_o[c] <= start_ok[c];
                if (in_rst[c])
                    busy[c] <= 1'b0;
                else if (start_ok[c])
                    busy[c] <= 1'b1;
                else if (done_i[c])
                    busy[c] <= 1'b0;
                if (ovf_set[c])
                    ovf[c] <= 1'b1;
                else if (wr_clr && wd[c])
                    ovf[c] <= 1'b0;
                if (in_rst[c]) begin
                    wp[c]  <= '0;
                    rp[c]  <= '0;
                    cnt[c] <= '0;
                end else begin
                    if (push_ok[c]) begin
                        mem[c][wp[c]] <= res_data_i[c*RES_W +: RES_W];
                        wp[c] <= wp[c] + AW'(1);
                    end
                    if (pop[c])
                        rp[c] <= rp[c] + AW'(1);
                    if (push_ok[c] && !pop[c])
                        cnt[c] <= cnt[c] + (AW+1)'(1);
                    else if (!push_ok[c] && pop[c])
                        cnt[c] <= cnt[c] - (AW+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_hls_ctl_mc.sv
// Directed bench for hls_ctl_mc: reset, pointer commit, soft reset/start,
// result FIFO order, overflow, full push+pop and mid-operation flush.
module tb_hls_ctl_mc;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   res_write = '0;
    logic [127:0] res_data = '0;
    logic [3:0]   done = '0;
    logic [3:0]   rst_k;
    logic [3:0]   start;
    logic [255:0] ptr;

    int nvec = 0;
    int nfail = 0;

    hls_ctl_mc_if bus ();

    hls_ctl_mc dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .csr         (bus),
        .res_write_i (res_write),
        .res_data_i  (res_data),
        .done_i      (done),
        .rst_o       (rst_k),
        .start_o     (start),
        .ptr_o       (ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        @(negedge clk);
        bus.write     = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.address = a;
        bus.read    = 1'b1;
        @(negedge clk);
        bus.read    = 1'b0;
        if (!bus.readdata_valid) begin
            nfail++;
            $display("FAIL rd_valid: got 0 expected 1");
        end
        d = bus.readdata;
    endtask

    task automatic push1(input logic [31:0] d);
        @(negedge clk);
        res_write[1]     = 1'b1;
        res_data[63:32]  = d;
        @(negedge clk);
        res_write[1]     = 1'b0;
    endtask

    task automatic pop_push1(input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        bus.address     = 3'd5;
        bus.read        = 1'b1;
        res_write[1]    = 1'b1;
        res_data[63:32] = d;
        @(negedge clk);
        bus.read        = 1'b0;
        res_write[1]    = 1'b0;
        r = bus.readdata;
    endtask

    initial begin
        logic [31:0] r;
        int rh, sh;
        bus.address   = '0;
        bus.writedata = '0;
        bus.write     = 1'b0;
        bus.read      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_o_in_reset", 64'(rst_k), 64'hF);
        end
        chk("ptr_reset", ptr[63:0] | ptr[127:64] | ptr[191:128]
            | ptr[255:192], 64'h0);
        chk("start_reset", 64'(start), 64'h0);
        chk("valid_reset", 64'(bus.readdata_valid), 64'h0);
        chk("waitrequest", 64'(bus.waitrequest), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_o_released", 64'(rst_k), 64'h0);
        csr_rd(3'd1, r);
        chk("status_reset", 64'(r), 64'h0);
        csr_rd(3'd6, r);
        chk("rescnt_reset", 64'(r), 64'h0);
        @(negedge clk);
        chk("valid_drops", 64'(bus.readdata_valid), 64'h0);
        csr_rd(3'd0, r);
        chk("ctrl_reads_0", 64'(r), 64'h0);

        csr_wr(3'd2, 32'd2);
        csr_wr(3'd3, 32'hDEADBEEF);
        chk("ptr2_before_hi", ptr[191:128], 64'h0);
        csr_wr(3'd4, 32'h12);
        chk("ptr2_commit", ptr[191:128], 64'h00000012_DEADBEEF);
        chk("ptr_others", ptr[127:0] | ptr[255:192], 64'h0);
        csr_rd(3'd3, r);
        chk("ptr_lo_rd", 64'(r), 64'hDEADBEEF);
        csr_rd(3'd4, r);
        chk("ptr_hi_rd", 64'(r), 64'h12);
        csr_wr(3'd2, 32'd5);
        csr_rd(3'd2, r);
        chk("chsel_ignore", 64'(r), 64'h2);

        csr_wr(3'd0, 32'h0101);
        rh = 0;
        sh = 0;
        for (int i = 0; i < 8; i++) begin
            rh += int'(rst_k[0]);
            sh += int'(start[0]);
            @(negedge clk);
        end
        chk("soft_rst_len", 64'(rh), 64'd4);
        chk("rst_wins_start", 64'(sh), 64'd0);
        csr_wr(3'd0, 32'h0100);
        chk("start_pulse", 64'(start), 64'h1);
        @(negedge clk);
        chk("start_one_cyc", 64'(start), 64'h0);
        csr_rd(3'd1, r);
        chk("busy0_set", 64'(r), 64'h1);
        csr_wr(3'd0, 32'h0100);
        chk("start_while_busy", 64'(start), 64'h0);
        @(negedge clk);
        done[0] = 1'b1;
        @(negedge clk);
        done[0] = 1'b0;
        csr_rd(3'd1, r);
        chk("busy0_done", 64'(r), 64'h0);

        csr_wr(3'd2, 32'd1);
        for (int i = 0; i < 8; i++)
            push1(32'h11 + 32'(i));
        csr_rd(3'd1, r);
        chk("status_ne1", 64'(r), 64'h200);
        push1(32'h19);
        csr_rd(3'd1, r);
        chk("status_ovf1", 64'(r), 64'h20200);
        csr_rd(3'd6, r);
        chk("rescnt_full", 64'(r), 64'd8);
        for (int i = 0; i < 8; i++) begin
            csr_rd(3'd5, r);
            chk($sformatf("pop_%0d", i), 64'(r), 64'h11 + 64'(i));
        end
        csr_rd(3'd5, r);
        chk("pop_empty", 64'(r), 64'h0);
        csr_rd(3'd6, r);
        chk("rescnt_drained", 64'(r), 64'd0);
        csr_wr(3'd7, 32'h2);
        csr_rd(3'd1, r);
        chk("ovf_clear", 64'(r), 64'h0);

        pop_push1(32'h77, r);
        chk("popempty_push", 64'(r), 64'h0);
        csr_rd(3'd5, r);
        chk("pushed_on_empty", 64'(r), 64'h77);

        for (int i = 0; i < 8; i++)
            push1(32'h21 + 32'(i));
        pop_push1(32'h29, r);
        chk("full_pp_data", 64'(r), 64'h21);
        csr_rd(3'd6, r);
        chk("full_pp_cnt", 64'(r), 64'd8);
        csr_rd(3'd1, r);
        chk("full_pp_noovf", 64'(r), 64'h200);
        csr_rd(3'd5, r);
        chk("head_adv", 64'(r), 64'h22);
        for (int i = 0; i < 4; i++)
            csr_rd(3'd5, r);
        csr_rd(3'd6, r);
        chk("three_queued", 64'(r), 64'd3);

        csr_wr(3'd3, 32'h12345678);
        csr_wr(3'd4, 32'hAB);
        csr_wr(3'd0, 32'h0200);
        csr_rd(3'd1, r);
        chk("busy1_ne1", 64'(r), 64'h202);
        csr_wr(3'd0, 32'h0002);
        chk("rst1_high", 64'(rst_k), 64'h2);
        push1(32'h55);
        for (int i = 0; i < 4; i++)
            @(negedge clk);
        chk("rst1_low", 64'(rst_k), 64'h0);
        csr_rd(3'd6, r);
        chk("flush_cnt", 64'(r), 64'd0);
        csr_rd(3'd1, r);
        chk("flush_status", 64'(r), 64'h0);
        chk("ptr1_kept", ptr[127:64], 64'h000000AB_12345678);
        chk("ptr2_kept", ptr[191:128], 64'h00000012_DEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/hls_ctl_mc.md
Name: hls_ctl_mc

Overview:
Multi-channel control/status block for the Aho-Corasick HLS match engines. It sits between the host Avalon-MM CSR slave and CH_CNT HLS kernel instances. Per channel it holds the buffer pointer, generates stretched soft resets and start pulses, tracks busy/done, and queues kernel results in a small FIFO that the host drains by reading.

Parameters:
CH_CNT, 4, number of HLS kernel channels (1..8)
PTR_W, 64, pointer width per channel (33..64)
RES_W, 32, result word width (≤32)
RES_DEPTH, 8, per-channel result FIFO depth (power of 2, ≥2)
RST_PULSE, 4, soft-reset pulse length in cycles (≥1)

Ports:
clk_i  in  1  single clock
rst_n_i  in  1  synchronous active-low reset
csr_address_i  in  3  word address
csr_write_i  in  1  write strobe
csr_writedata_i  in  32  write data
csr_read_i  in  1  read strobe
csr_readdata_o  out  32  read data, valid with csr_readdata_valid_o
csr_readdata_valid_o  out  1  one cycle after csr_read_i
csr_waitrequest_o  out  1  tied 0
res_write_i  in  CH_CNT  per-channel result strobe from kernel
res_data_i  in  CH_CNT*RES_W  per-channel result data, channel c at [c*RES_W +: RES_W]
done_i  in  CH_CNT  per-channel completion pulse
rst_o  out  CH_CNT  per-channel kernel reset, active high
start_o  out  CH_CNT  per-channel one-cycle start pulse
ptr_o  out  CH_CNT*PTR_W  per-channel pointer

Behaviour:
- All state updates on rising clk_i. rst_n_i=0 (synchronous): ptr_o=0, lo shadow=0, ch_sel=0, start_o=0, busy=0, overflow=0, all FIFOs empty, csr_readdata_o=0, csr_readdata_valid_o=0, reset counters=0. rst_o is combinationally all-ones while rst_n_i=0.
- CSR map (word addr): 0 CTRL (W): bits[CH_CNT-1:0] soft-reset request, bits[8+CH_CNT-1:8] start request; reads 0. 1 STATUS (R): [7:0] busy, [15:8] FIFO non-empty, [23:16] overflow sticky; unused bits 0. 2 CH_SEL (R/W): [2:0]; writes ≥CH_CNT ignored. 3 PTR_LO (R/W): write loads 32-bit shadow only; read returns ptr_o[ch_sel][31:0]. 4 PTR_HI (R/W): write commits {wdata[PTR_W-33:0], shadow} to ptr_o[ch_sel] atomically; read returns upper bits zero-extended. 5 RES_POP (R): returns head of ch_sel FIFO and pops; empty -> returns 0, no state change. 6 RES_CNT (R): occupancy of ch_sel FIFO. 7 OVF_CLR (W1C): bit c clears overflow[c].
- Read latency 1: csr_readdata_o/valid registered from csr_read_i; valid deasserts next cycle unless another read. Reading non-pop registers has no side effect. Simultaneous read and write in one cycle: read returns pre-write value.
- Soft reset: CTRL write with bit c set loads counter[c]=RST_PULSE; rst_o[c]=1 while counter[c]≠0 (asserts the cycle after the write, for exactly RST_PULSE cycles). Re-request during pulse reloads the counter. While rst_o[c]=1: FIFO c flushed, busy[c]=0, start requests and res_write_i[c] ignored; ptr_o[c] and overflow[c] retained.
- Start: CTRL write with start bit c, channel not in reset and busy[c]=0 -> start_o[c]=1 for the next cycle only, busy[c] set same edge. Start while busy is ignored. Soft reset and start for the same channel in the same write: reset wins, no start.
- done_i[c] clears busy[c]; done coincident with an accepted start: busy stays 1.
- Result FIFO: push on res_write_i[c]; if full and no concurrent pop, data dropped and overflow[c] set. Push+pop same cycle on full FIFO: both succeed, no overflow. Push+pop on empty: popped read returns 0, pushed word stored. Pointers wrap mod RES_DEPTH; RES_CNT ranges 0..RES_DEPTH.

Test Plan:
- Reset: assert rst_n_i 3 cycles -> rst_o=all-ones during, ptr_o=0, STATUS read=0x0, RES_CNT=0.
- Pointer: CH_SEL=2, PTR_LO=0xDEADBEEF, PTR_HI=0x00000012 -> ptr_o[2]=0x00000012_DEADBEEF, updated only after HI write; other channels unchanged.
- Soft reset/start: CTRL=0x0101 -> rst_o[0] high 4 cycles, start_o[0] never pulses; then CTRL=0x0100 -> start_o[0] one pulse, busy[0]=1; second CTRL=0x0100 ignored; done_i[0] -> STATUS busy[0]=0.
- FIFO: push 0x11..0x18 on ch1, push 0x19 -> overflow[1]=1, RES_CNT=8; 8 RES_POP reads return 0x11..0x18 in order, ninth returns 0; OVF_CLR=0x2 clears it.
- Full FIFO push+pop same cycle -> RES_CNT stays 8, no overflow, head advances.
- Mid-operation soft reset of ch1 with 3 queued results -> RES_CNT=0, busy[1]=0, ptr_o[1] unchanged.
